// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Drives one shared signed multiply-accumulate datapath to compute C = A x B.
//   A (MxK), B (KxN) and C (MxN) are row-major in external synchronous RAMs
//   with a fixed one-cycle read latency. One MAC is issued per cycle.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin a product (looked at only while idle)
//   busy, done         busy outside IDLE; done is a one-cycle completion pulse
//   a_addr, b_addr     registered read addresses (i*K+k, k*N+j)
//   a_rdata, b_rdata   read data, valid one cycle after the address
//   c_wr_en, c_addr,   result write; held stable until c_wr_ready
//   c_wdata, c_wr_ready
module matmul_sequencer #(
   parameter int M      = 2,
   parameter int K      = 2,
   parameter int N      = 2,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   localparam int AW_A  = (M * K > 1) ? $clog2(M * K) : 1,
   localparam int AW_B  = (K * N > 1) ? $clog2(K * N) : 1,
   localparam int AW_C  = (M * N > 1) ? $clog2(M * N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [AW_A-1:0]   a_addr,
   output logic [AW_B-1:0]   b_addr,
   input  logic [DATA_W-1:0] a_rdata,
   input  logic [DATA_W-1:0] b_rdata,
   output logic              c_wr_en,
   output logic [AW_C-1:0]   c_addr,
   output logic [ACC_W-1:0]  c_wdata,
   input  logic              c_wr_ready
);
   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam int JW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(M - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

   state_t                     state;
   logic [IW-1:0]              i;
   logic [JW-1:0]              j;
   logic [KW-1:0]              k;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [2*DATA_W-1:0] prod;
   logic                       first;

   // Full-width signed product, sign-extended into the accumulator width.
   assign prod     = (2*DATA_W)'($signed(a_rdata)) * (2*DATA_W)'($signed(b_rdata));
   assign prod_ext = ACC_W'(prod);

   // Data for k arrives while k+1 is being addressed, so the first product of
   // an element lands in FETCH k=1 (or in DRAIN when K=1). Loading instead of
   // adding there removes the need for a separate clear cycle.
   always_comb begin
      first    = ((state == FETCH) && (k == KW'(1))) || ((state == DRAIN) && (K == 1));
      acc_next = first ? prod_ext : acc + prod_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         c_wr_en <= 1'b0;
         a_addr  <= '0;
         b_addr  <= '0;
         c_addr  <= '0;
         c_wdata <= '0;
         acc     <= '0;
         i       <= '0;
         j       <= '0;
         k       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= FETCH;
                  busy   <= 1'b1;
                  i      <= '0;
                  j      <= '0;
                  k      <= '0;
                  a_addr <= '0;
                  b_addr <= '0;
               end
            end
            FETCH: begin
               if (k != '0) acc <= acc_next;
               if (k == K_LAST) begin
                  state <= DRAIN;
               end else begin
                  // Addresses are registered, so load the ones for k+1 now.
                  k      <= k + KW'(1);
                  a_addr <= AW_A'(int'(i) * K + int'(k) + 1);
                  b_addr <= AW_B'((int'(k) + 1) * N + int'(j));
               end
            end
            DRAIN: begin
               acc     <= acc_next;
               c_wdata <= acc_next;
               c_addr  <= AW_C'(int'(i) * N + int'(j));
               c_wr_en <= 1'b1;
               state   <= WRITE;
            end
            WRITE: begin
               if (c_wr_ready) begin
                  c_wr_en <= 1'b0;
                  k       <= '0;
                  if (i == I_LAST && j == J_LAST) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     if (j == J_LAST) begin
                        j      <= '0;
                        i      <= i + IW'(1);
                        a_addr <= AW_A'((int'(i) + 1) * K);
                        b_addr <= '0;
                     end else begin
                        j      <= j + JW'(1);
                        a_addr <= AW_A'(int'(i) * K);
                        b_addr <= AW_B'(int'(j) + 1);
                     end
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer
//   Three instances: 2x2x2 (16/40 bit), 1x1x1 (8/40 bit), 1x2x1 (8/16 bit).
//   Each has a one-cycle-latency RAM model. Cycle numbers are relative to the
//   cycle in which start is sampled (cycle 0).
module tb_matmul_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   t0    = 0;
   int   errors = 0;
   int   checks = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance 1: M=K=N=2 ----------------
   logic        start1 = 1'b0, busy1, done1, wen1, ready1;
   logic [1:0]  a1_addr, b1_addr, c1_addr;
   logic [15:0] a1_rd, b1_rd;
   logic [39:0] wd1;
   logic [15:0] mA1[4], mB1[4];
   int          bp_from = -1, bp_to = -2;

   assign ready1 = !((cyc - t0) >= bp_from && (cyc - t0) <= bp_to);
   always @(posedge clk) begin
      a1_rd <= mA1[a1_addr];
      b1_rd <= mB1[b1_addr];
   end

   matmul_sequencer #(.M(2), .K(2), .N(2), .DATA_W(16), .ACC_W(40)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .a_addr(a1_addr), .b_addr(b1_addr), .a_rdata(a1_rd), .b_rdata(b1_rd),
      .c_wr_en(wen1), .c_addr(c1_addr), .c_wdata(wd1), .c_wr_ready(ready1));

   // ---------------- instance 2: M=K=N=1, DATA_W=8 ----------------
   logic        start2 = 1'b0, busy2, done2, wen2;
   logic        a2_addr, b2_addr, c2_addr;
   logic [7:0]  a2_rd, b2_rd;
   logic [39:0] wd2;
   logic [7:0]  mA2[2], mB2[2];
   always @(posedge clk) begin
      a2_rd <= mA2[a2_addr];
      b2_rd <= mB2[b2_addr];
   end

   matmul_sequencer #(.M(1), .K(1), .N(1), .DATA_W(8), .ACC_W(40)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
      .a_addr(a2_addr), .b_addr(b2_addr), .a_rdata(a2_rd), .b_rdata(b2_rd),
      .c_wr_en(wen2), .c_addr(c2_addr), .c_wdata(wd2), .c_wr_ready(1'b1));

   // ---------------- instance 3: M=N=1, K=2, DATA_W=8, ACC_W=16 ----------------
   logic        start3 = 1'b0, busy3, done3, wen3;
   logic        a3_addr, b3_addr, c3_addr;
   logic [7:0]  a3_rd, b3_rd;
   logic [15:0] wd3;
   logic [7:0]  mA3[2], mB3[2];
   always @(posedge clk) begin
      a3_rd <= mA3[a3_addr];
      b3_rd <= mB3[b3_addr];
   end

   matmul_sequencer #(.M(1), .K(2), .N(1), .DATA_W(8), .ACC_W(16)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
      .a_addr(a3_addr), .b_addr(b3_addr), .a_rdata(a3_rd), .b_rdata(b3_rd),
      .c_wr_en(wen3), .c_addr(c3_addr), .c_wdata(wd3), .c_wr_ready(1'b1));

   // ---------------- monitors (sample on falling edge) ----------------
   int          nwr, ndone, dcyc;
   int          wcyc[8];
   logic [1:0]  waddr[8];
   logic [39:0] wdat[8];
   logic        tr_busy[64], tr_wen[64];
   logic [1:0]  tr_a[64], tr_b[64], tr_c[64];
   logic [39:0] tr_d[64];
   int          n2, nd2, w2cyc, d2cyc, n3, nd3, w3cyc, d3cyc;
   logic        w2addr, w3addr;
   logic [39:0] w2dat;
   logic [15:0] w3dat;
   int          r;

   always @(negedge clk) begin
      r = cyc - t0;
      if (r >= 0 && r < 64) begin
         tr_busy[r] = busy1; tr_wen[r] = wen1;
         tr_a[r] = a1_addr;  tr_b[r] = b1_addr;
         tr_c[r] = c1_addr;  tr_d[r] = wd1;
      end
      if (wen1 && ready1 && nwr < 8) begin
         wcyc[nwr] = r; waddr[nwr] = c1_addr; wdat[nwr] = wd1; nwr++;
      end
      if (done1) begin dcyc = r; ndone++; end
      if (wen2) begin w2cyc = r; w2addr = c2_addr; w2dat = wd2; n2++; end
      if (done2) begin d2cyc = r; nd2++; end
      if (wen3) begin w3cyc = r; w3addr = c3_addr; w3dat = wd3; n3++; end
      if (done3) begin d3cyc = r; nd3++; end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // Runs instance 1 for ncyc cycles after start; optional extra start pulses
   // at cycles p1/p2 and a one-cycle reset at rst_at (-1 = none).
   task automatic run1(input int p1, input int p2, input int rst_at, input int ncyc);
      nwr = 0; ndone = 0; dcyc = -1;
      for (int e = 0; e < 8; e++) wcyc[e] = -1;
      @(posedge clk); #1;
      t0 = cyc; start1 = 1'b1;
      for (int rr = 1; rr <= ncyc; rr++) begin
         @(posedge clk); #1;
         start1 = (rr == p1 || rr == p2);
         rst_n  = (rr != rst_at);
      end
      start1 = 1'b0; rst_n = 1'b1;
   endtask

   typedef struct packed {
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      logic [3:0][39:0] c;
   } vec_t;

   vec_t vecs[4];

   task automatic load1(input int v);
      for (int e = 0; e < 4; e++) begin
         mA1[e] = vecs[v].a[e];
         mB1[e] = vecs[v].b[e];
      end
   endtask

   initial begin
      // Element e of each field is index e (index 0 is the rightmost literal).
      vecs[0].a = {16'd4, 16'd3, 16'd2, 16'd1};
      vecs[0].b = {16'd1, 16'd0, 16'd0, 16'd1};
      vecs[0].c = {40'd4, 40'd3, 40'd2, 40'd1};
      vecs[1].a = {16'd4, 16'd3, 16'd2, 16'd1};
      vecs[1].b = {16'd8, 16'd7, 16'd6, 16'd5};
      vecs[1].c = {40'd50, 40'd43, 40'd22, 40'd19};
      vecs[2].a = {-16'sd4, 16'sd3, -16'sd2, -16'sd1};
      vecs[2].b = {-16'sd8, 16'sd7, 16'sd6, 16'sd5};
      vecs[2].c = {40'sd50, -40'sd13, 40'sd10, -40'sd19};
      vecs[3].a = {16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
      vecs[3].b = {16'h8000, 16'h8000, 16'h0000, 16'h7FFF};
      vecs[3].c = {40'd1073741824, 40'd32768, 40'd1073741824, 40'd2147418113};
      n2 = 0; nd2 = 0; n3 = 0; nd3 = 0;
      for (int e = 0; e < 4; e++) begin mA1[e] = '0; mB1[e] = '0; end
      for (int e = 0; e < 2; e++) begin mA2[e] = '0; mB2[e] = '0; mA3[e] = '0; mB3[e] = '0; end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy1), 0);
      chk("rst_done", 64'(done1), 0);
      chk("rst_wen", 64'(wen1), 0);
      chk("rst_a_addr", 64'(a1_addr), 0);
      chk("rst_b_addr", 64'(b1_addr), 0);
      chk("rst_c_addr", 64'(c1_addr), 0);
      chk("rst_c_wdata", 64'(wd1), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Table: full 2x2x2 products with ready held high
      for (int v = 0; v < 4; v++) begin
         load1(v);
         run1(-1, -1, -1, 30);
         for (int e = 0; e < 4; e++) begin
            chk($sformatf("v%0d_addr%0d", v, e), 64'(waddr[e]), 64'(e));
            chk($sformatf("v%0d_data%0d", v, e), 64'(wdat[e]), 64'(vecs[v].c[e]));
            chk($sformatf("v%0d_cyc%0d", v, e), 64'(wcyc[e]), 64'(4 * e + 4));
         end
         chk($sformatf("v%0d_nwr", v), 64'(nwr), 4);
         chk($sformatf("v%0d_done_cyc", v), 64'(dcyc), 17);
         chk($sformatf("v%0d_ndone", v), 64'(ndone), 1);
         chk($sformatf("v%0d_busy17", v), 64'(tr_busy[17]), 1);
         chk($sformatf("v%0d_idle18", v), 64'(tr_busy[18]), 0);
         if (v == 1) begin
            chk("e2_a0", 64'(tr_a[9]), 2);
            chk("e2_b0", 64'(tr_b[9]), 0);
            chk("e2_a1", 64'(tr_a[10]), 3);
            chk("e2_b1", 64'(tr_b[10]), 2);
         end
      end

      // Backpressure: ready low in cycles 8..10 on element 1
      load1(0);
      bp_from = 8; bp_to = 10;
      run1(-1, -1, -1, 30);
      bp_from = -1; bp_to = -2;
      for (int c = 8; c <= 11; c++) begin
         chk($sformatf("bp_wen%0d", c), 64'(tr_wen[c]), 1);
         chk($sformatf("bp_addr%0d", c), 64'(tr_c[c]), 1);
         chk($sformatf("bp_data%0d", c), 64'(tr_d[c]), 2);
      end
      chk("bp_cyc1", 64'(wcyc[1]), 11);
      chk("bp_cyc3", 64'(wcyc[3]), 19);
      chk("bp_data3", 64'(wdat[3]), 4);
      chk("bp_done_cyc", 64'(dcyc), 20);
      chk("bp_ndone", 64'(ndone), 1);

      // Reset mid-operation in cycle 6
      load1(0);
      run1(-1, -1, 6, 30);
      chk("rst6_busy6", 64'(tr_busy[6]), 1);
      chk("rst6_busy7", 64'(tr_busy[7]), 0);
      chk("rst6_wen7", 64'(tr_wen[7]), 0);
      chk("rst6_nwr", 64'(nwr), 1);
      chk("rst6_ndone", 64'(ndone), 0);

      // start pulses while busy (incl. the done cycle) are ignored
      load1(0);
      run1(2, 17, -1, 30);
      for (int e = 0; e < 4; e++) begin
         chk($sformatf("sb_data%0d", e), 64'(wdat[e]), 64'(vecs[0].c[e]));
         chk($sformatf("sb_cyc%0d", e), 64'(wcyc[e]), 64'(4 * e + 4));
      end
      chk("sb_nwr", 64'(nwr), 4);
      chk("sb_done_cyc", 64'(dcyc), 17);
      chk("sb_ndone", 64'(ndone), 1);
      chk("sb_idle18", 64'(tr_busy[18]), 0);
      chk("sb_idle19", 64'(tr_busy[19]), 0);

      // M=K=N=1: -3 * 5
      mA2[0] = 8'hFD; mB2[0] = 8'd5;
      @(posedge clk); #1;
      t0 = cyc; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("k1_nwr", 64'(n2), 1);
      chk("k1_addr", 64'(w2addr), 0);
      chk("k1_data", 64'(w2dat), 64'(40'hFF_FFFF_FFF1));
      chk("k1_wcyc", 64'(w2cyc), 3);
      chk("k1_done_cyc", 64'(d2cyc), 4);
      chk("k1_ndone", 64'(nd2), 1);

      // ACC_W=16 wrap: 2 * (-128 * -128) = 32768 -> 16'h8000
      mA3[0] = 8'h80; mA3[1] = 8'h80; mB3[0] = 8'h80; mB3[1] = 8'h80;
      @(posedge clk); #1;
      t0 = cyc; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("wrap_nwr", 64'(n3), 1);
      chk("wrap_addr", 64'(w3addr), 0);
      chk("wrap_data", 64'(w3dat), 64'(16'h8000));
      chk("wrap_wcyc", 64'(w3cyc), 4);
      chk("wrap_done_cyc", 64'(d3cyc), 5);
      chk("wrap_ndone", 64'(nd3), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
